spi_reg_bridge: RTL



---
 rtl/spi_reg_bridge.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns 16-bit command/data frames into
// register-file accesses. Writes present wr_addr/wr_data and flip wr_toggle once
// per committed byte. Reads drive rd_addr and shift rd_data out on miso.
// The SPI pins are oversampled in the clk domain, so f_clk must be >= 8 x f_sclk.
// Optional build macro: SPI_BURST_EN. When it is defined, the frame stays in DATA
// after each byte and the address auto-increments modulo 64.
// Handshake: wr_toggle is a level-change strobe. wr_addr and wr_data are valid
// from the cycle the toggle flips until the next flip. The consumer needs no
// ready signal because each flip is exactly one committed write.
// state_dbg exposes the FSM state (0=IDLE 1=CMD 2=DATA 3=DONE) for checkers.
module spi_reg_bridge #(
  parameter int CMD_W       = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_toggle,
  output logic [CMD_W-3:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CMD_W-3:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state_dbg
);

  localparam int ADDR_W = CMD_W - 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s, cs_s, mosi_s, rise, fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [CMD_W-2:0]  cmd_sh;      // top bit of the command is consumed on the last shift
  logic [DATA_W-2:0] data_sh;
  logic [CMD_W-1:0]  cmd_next;
  logic [DATA_W-1:0] data_next;
  logic              last_cmd_bit, last_data_bit;
  logic [ADDR_W-1:0] addr;
  logic              is_read;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_reload;   // next falling event snapshots rd_data
  logic              wr_pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  assign sclk_s        = sclk_sync[SYNC_STAGES-1];
  assign cs_s          = cs_sync[SYNC_STAGES-1];
  assign mosi_s        = mosi_sync[SYNC_STAGES-1];
  assign rise          = sclk_s & ~sclk_d;
  assign fall          = ~sclk_s & sclk_d;
  assign cmd_next      = {cmd_sh, mosi_s};
  assign data_next     = {data_sh, mosi_s};
  assign last_cmd_bit  = (bit_cnt == CNT_W'(CMD_W - 1));
  assign last_data_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign state_dbg     = state_q;
  assign miso          = (state_q == DATA && is_read) ? tx_shift[DATA_W-1] : 1'b0;

  // Pin synchronizers plus one extra sclk flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a cs_n rise anywhere in a frame aborts back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!cs_s) state_d = CMD;
      CMD: begin
        if (cs_s)                      state_d = IDLE;
        else if (rise && last_cmd_bit) state_d = DATA;
      end
      DATA: begin
        if (cs_s)                       state_d = IDLE;
`ifdef SPI_BURST_EN
        else                            state_d = DATA;
`else
        else if (rise && last_data_bit) state_d = DONE;
`endif
      end
      DONE: if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: shifting, address latch, write commit and MISO shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      cmd_sh    <= '0;
      data_sh   <= '0;
      addr      <= '0;
      is_read   <= 1'b0;
      tx_shift  <= '0;
      tx_reload <= 1'b0;
      wr_pend   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      wr_toggle <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
    end else begin
      wr_pend <= 1'b0;
      // The commit lands one clk after the last data bit is shifted in.
      if (wr_pend) begin
        wr_addr   <= pend_addr;
        wr_data   <= pend_data;
        wr_toggle <= ~wr_toggle;
      end
      case (state_q)
        IDLE: begin
          bit_cnt   <= '0;
          tx_shift  <= '0;
          tx_reload <= 1'b0;
        end
        CMD: begin
          if (!cs_s && rise) begin
            cmd_sh <= cmd_next[CMD_W-2:0];
            if (last_cmd_bit) begin
              bit_cnt   <= '0;
              addr      <= cmd_next[ADDR_W-1:0];
              rd_addr   <= cmd_next[ADDR_W-1:0];
              is_read   <= ~cmd_next[CMD_W-1];
              tx_reload <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (!cs_s && rise) begin
            data_sh <= data_next[DATA_W-2:0];
            if (last_data_bit) begin
              bit_cnt   <= '0;
              tx_reload <= 1'b1;
              if (!is_read) begin
                wr_pend   <= 1'b1;
                pend_addr <= addr;
                pend_data <= data_next;
              end
`ifdef SPI_BURST_EN
              addr    <= addr + ADDR_W'(1);
              rd_addr <= addr + ADDR_W'(1);
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (!cs_s && fall && is_read) begin
            if (tx_reload) begin
              tx_shift  <= rd_data;
              tx_reload <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
